// File: rtl/multicycle_processor_if.sv
// Unified instruction/data memory port of the multi-cycle core.
//   req    core -> mem  request valid
//   we     core -> mem  1 = write (sw), 0 = read
//   addr   core -> mem  word-aligned byte address
//   wdata  core -> mem  store data
//   rdata  mem -> core  load/fetch data, valid while ready=1
//   ready  mem -> core  request accepted/completed this cycle
// Address, direction and store data are held stable while req=1 until ready=1.
interface multicycle_processor_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core: shared ALU, one memory port with a ready
// handshake, fault detection, terminal HALT state and a retire strobe.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   mem       memory port (master side of multicycle_processor_if)
//   retire_o  one-cycle pulse in the final cycle of each instruction
//   pc_out_o  current PC register
//   halted_o  core stopped in HALT
//   fault_o   halt cause: 0 none, 1 illegal, 2 misaligned, 3 timeout, 4 overflow
// Build option: define MULTICYCLE_OVF_TRAP_EN to trap signed overflow on
// add/sub/addi (fault 4, no writeback); otherwise results wrap.
//
// state    | meaning
// S_FETCH  | request instruction at PC, latch IR, PC += 4
// S_DECODE | read rs/rt, form branch target, reject unknown encodings
// S_EXEC   | ALU / address compute; branches and jumps complete here
// S_MEM    | data access for lw/sw
// S_WB     | register writeback for ALU ops and lw
// S_HALT   | stopped until reset
module multicycle_processor #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_processor_if.master mem,
  output logic                   retire_o,
  output logic [31:0]            pc_out_o,
  output logic                   halted_o,
  output logic [2:0]             fault_o
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                         OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101,
                         OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_JR  = 6'b001000,
                         F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR  = 6'b100101, F_SLT = 6'b101010;
  localparam logic [2:0] FLT_ILLEGAL = 3'd1, FLT_MISALIGN = 3'd2, FLT_TIMEOUT = 3'd3;

  // Stall down-counter: reloads at every new request, fault when it is
  // already at zero and the memory is still not ready.
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_RELOAD = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]    tgt_q, tgt_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [2:0]     fault_q, fault_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [31:0]    rf_q [0:31];

  logic           rf_we, retire, req_int, tmo_hit, legal, is_jr;
  logic [4:0]     rf_waddr;
  logic [31:0]    rf_wdata, alu_res;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext, jump_tgt;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'd0, ir_q[15:0]};
  assign jump_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign is_jr    = (opcode == OP_RTYPE) && (funct == F_JR);

  // A misaligned PC never reaches the bus; FETCH halts instead.
  assign req_int   = ((state_q == S_FETCH) && (pc_q[1:0] == 2'b00)) || (state_q == S_MEM);
  assign tmo_hit   = (MEM_TIMEOUT != 0) && req_int && !mem.ready && (tmo_q == '0);
  assign mem.req   = req_int & ~reset;
  assign mem.we    = (state_q == S_MEM) && (opcode == OP_SW);
  assign mem.addr  = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem.wdata = b_q;

  assign retire_o = retire;
  assign pc_out_o = pc_q;
  assign halted_o = (state_q == S_HALT);
  assign fault_o  = fault_q;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_JR: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = 32'd0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_res = a_q + b_q;
          F_SUB:   alu_res = a_q - b_q;
          F_AND:   alu_res = a_q & b_q;
          F_OR:    alu_res = a_q | b_q;
          F_SLT:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
          F_SLL:   alu_res = b_q << shamt;
          F_SRL:   alu_res = b_q >> shamt;
          default: alu_res = 32'd0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm_sext;
      OP_SLTI: alu_res = {31'd0, $signed(a_q) < $signed(imm_sext)};
      OP_ANDI: alu_res = a_q & imm_zext;
      OP_ORI:  alu_res = a_q | imm_zext;
      OP_LUI:  alu_res = {ir_q[15:0], 16'd0};
      default: alu_res = 32'd0;
    endcase
  end

`ifdef MULTICYCLE_OVF_TRAP_EN
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    if (opcode == OP_RTYPE && funct == F_ADD)
      ovf = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
    else if (opcode == OP_RTYPE && funct == F_SUB)
      ovf = (a_q[31] != b_q[31]) && (alu_res[31] != a_q[31]);
    else if (opcode == OP_ADDI)
      ovf = (a_q[31] == imm_sext[31]) && (alu_res[31] != a_q[31]);
  end
`endif

  always_comb begin
    tmo_d = tmo_q;
    if (!req_int || mem.ready) tmo_d = TMO_RELOAD;
    else if (tmo_q != '0)      tmo_d = tmo_q - TW'(1);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    tgt_d    = tgt_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    fault_d  = fault_q;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_HALT;
          fault_d = FLT_MISALIGN;
        end else if (mem.ready) begin
          ir_d    = mem.rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_HALT;
          fault_d = FLT_TIMEOUT;
        end
      end
      S_DECODE: begin
        a_d   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        b_d   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
        tgt_d = pc_q + {imm_sext[29:0], 2'b00};
        if (!legal) begin
          state_d = S_HALT;
          fault_d = FLT_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_jr) begin
          pc_d    = a_q;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          case (opcode)
            OP_BEQ, OP_BNE: begin
              if ((a_q == b_q) == (opcode == OP_BEQ)) pc_d = tgt_q;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            OP_J, OP_JAL: begin
              pc_d     = jump_tgt;
              rf_we    = (opcode == OP_JAL);
              rf_waddr = 5'd31;
              rf_wdata = pc_q;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
            OP_LW, OP_SW: begin
              alu_d = alu_res;
              if (alu_res[1:0] != 2'b00) begin
                state_d = S_HALT;
                fault_d = FLT_MISALIGN;
              end else begin
                state_d = S_MEM;
              end
            end
            default: begin
              alu_d = alu_res;
`ifdef MULTICYCLE_OVF_TRAP_EN
              if (ovf) begin
                state_d = S_HALT;
                fault_d = 3'd4;
              end else begin
                state_d = S_WB;
              end
`else
              state_d = S_WB;
`endif
            end
          endcase
        end
      end
      S_MEM: begin
        if (mem.ready) begin
          if (opcode == OP_LW) begin
            mdr_d   = mem.rdata;
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (tmo_hit) begin
          state_d = S_HALT;
          fault_d = FLT_TIMEOUT;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      tgt_q   <= 32'd0;
      alu_q   <= 32'd0;
      mdr_q   <= 32'd0;
      fault_q <= 3'd0;
      tmo_q   <= TMO_RELOAD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tgt_q   <= tgt_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end
endmodule

// File: tb/tb_multicycle_processor.sv
module tb_multicycle_processor;
  localparam logic [31:0] ILL  = 32'hFC00_0000;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        retire_o;
  logic [31:0] pc_out_o;
  logic        halted_o;
  logic [2:0]  fault_o;

  multicycle_processor_if bus();

  multicycle_processor #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem(bus),
    .retire_o(retire_o), .pc_out_o(pc_out_o), .halted_o(halted_o), .fault_o(fault_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [0:127];
  int          wait_n;
  int          cyc, retires, stall_cyc, stab_err;
  logic [31:0] req_log [$];
  int          ret_cyc [$];
  int          n_chk, n_fail;

  // Memory model and monitor: ready is decided at the falling edge for the
  // current cycle, observations are taken 1 time unit later.
  initial begin : mem_model
    int          stall;
    logic        have_prev;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    stall = 0; have_prev = 1'b0; p_addr = 0; p_wdata = 0; p_we = 0;
    bus.ready = 1'b0;
    bus.rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (reset || !bus.req) begin
        bus.ready = 1'b0;
        stall = 0;
        have_prev = 1'b0;
      end else begin
        if (have_prev && (bus.addr !== p_addr || bus.we !== p_we || bus.wdata !== p_wdata))
          stab_err++;
        if (stall >= wait_n) begin
          bus.ready = 1'b1;
          bus.rdata = mem[bus.addr[8:2]];
          if (bus.we) mem[bus.addr[8:2]] = bus.wdata;
          stall = 0;
          have_prev = 1'b0;
        end else begin
          bus.ready = 1'b0;
          stall++;
          have_prev = 1'b1;
          p_addr = bus.addr; p_we = bus.we; p_wdata = bus.wdata;
        end
      end
      #1;
      if (!reset) begin
        cyc++;
        if (bus.req && bus.ready) req_log.push_back(bus.addr);
        if (bus.req && !bus.ready) stall_cyc++;
        if (retire_o) begin
          retires++;
          ret_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = ILL;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    cyc = 0; retires = 0; stall_cyc = 0; stab_err = 0;
    req_log.delete();
    ret_cyc.delete();
    #1 reset = 1'b0;
  endtask

  task automatic run_until_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!halted_o && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, {31'd0, halted_o}, 32'd1);
  endtask

  task automatic idle_after_halt(input string name);
    int sz;
    sz = req_log.size();
    repeat (5) @(negedge clk);
    #2;
    chk(name, req_log.size(), sz);
    chk({name, "_req"}, {31'd0, bus.req}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] instr;
    logic [31:0] exp_mem;
    logic [2:0]  exp_fault;
    int          exp_ret;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [31:0] exp_log [15];
    int          exp_rc  [11];
    vec_t        v;
    int          n;

    n_chk = 0; n_fail = 0; wait_n = 0;
    cyc = 0; retires = 0; stall_cyc = 0; stab_err = 0;
    reset = 1'b1;

    vecs.push_back('{"add",   32'd5,         32'hFFFF_FFFD, enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h20), 32'd2,         3'd1, 6});
    vecs.push_back('{"sub",   32'd5,         32'hFFFF_FFFD, enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h22), 32'd8,         3'd1, 6});
    vecs.push_back('{"and",   32'hF0F0_1234, 32'h0FF0_FF00, enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h24), 32'h00F0_1200, 3'd1, 6});
    vecs.push_back('{"or",    32'hF0F0_0000, 32'h0F0F_0001, enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h25), 32'hFFFF_0001, 3'd1, 6});
    vecs.push_back('{"slt_t", 32'hFFFF_FFFF, 32'd1,         enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h2A), 32'd1,         3'd1, 6});
    vecs.push_back('{"slt_f", 32'd1,         32'hFFFF_FFFF, enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h2A), 32'd0,         3'd1, 6});
    vecs.push_back('{"sll",   32'd0,         32'd1,         enc_r(5'd0, 5'd2, 5'd3, 5'd31, 6'h00), 32'h8000_0000, 3'd1, 6});
    vecs.push_back('{"srl",   32'd0,         32'h8000_0000, enc_r(5'd0, 5'd2, 5'd3, 5'd4,  6'h02), 32'h0800_0000, 3'd1, 6});
    vecs.push_back('{"addi",  32'd0,         32'd0,         enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF),    32'hFFFF_FFFF, 3'd1, 6});
    vecs.push_back('{"slti",  32'hFFFF_FFFD, 32'd0,         enc_i(6'h0A, 5'd1, 5'd3, 16'hFFFE),    32'd1,         3'd1, 6});
    vecs.push_back('{"andi",  32'hFFFF_FFFF, 32'd0,         enc_i(6'h0C, 5'd1, 5'd3, 16'hFFFF),    32'h0000_FFFF, 3'd1, 6});
    vecs.push_back('{"ori",   32'd0,         32'd0,         enc_i(6'h0D, 5'd1, 5'd3, 16'h8000),    32'h0000_8000, 3'd1, 6});
    vecs.push_back('{"lui",   32'd0,         32'd0,         enc_i(6'h0F, 5'd0, 5'd3, 16'h1234),    32'h1234_0000, 3'd1, 6});
    vecs.push_back('{"badfn", 32'd1,         32'd2,         enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h3F), SENT,          3'd1, 4});
`ifdef MULTICYCLE_OVF_TRAP_EN
    vecs.push_back('{"ovf",   32'h7FFF_FFFF, 32'd1,         enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h20), SENT,          3'd4, 4});
`else
    vecs.push_back('{"ovf",   32'h7FFF_FFFF, 32'd1,         enc_r(5'd1, 5'd2, 5'd3, 5'd0,  6'h20), 32'h8000_0000, 3'd1, 6});
`endif

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",     pc_out_o, 32'd0);
    chk("rst_halted", {31'd0, halted_o}, 32'd0);
    chk("rst_fault",  {29'd0, fault_o}, 32'd0);
    chk("rst_retire", {31'd0, retire_o}, 32'd0);
    chk("rst_req",    {31'd0, bus.req}, 32'd0);

    // addi/addi/add, zero-wait: third retire in cycle 12
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0100);
    mem[64] = SENT;
    wait_n = 0;
    do_reset();
    run_until_halt("p1_halt", 100);
    chk("p1_retires",  retires, 4);
    chk("p1_ret3_cyc", (ret_cyc.size() > 2) ? ret_cyc[2] : -1, 12);
    chk("p1_r3",       mem[64], 32'd2);
    chk("p1_fault",    {29'd0, fault_o}, 32'd1);
    idle_after_halt("p1_idle");

    // sw/lw with two wait states per access
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0008);
    mem[4] = enc_i(6'h23, 5'd0, 5'd4, 16'h0008);
    mem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0104);
    mem[65] = SENT;
    wait_n = 2;
    do_reset();
    run_until_halt("p2_halt", 200);
    chk("p2_mem8",     mem[2], 32'd2);
    chk("p2_r4",       mem[65], 32'd2);
    chk("p2_stable",   stab_err, 0);
    chk("p2_stalls",   stall_cyc, 20);
    chk("p2_last_ret", (ret_cyc.size() > 5) ? ret_cyc[5] : -1, 43);
    chk("p2_retires",  retires, 6);

    // Branches, jumps, memory ops, jr, then a misaligned lw
    clear_mem();
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1]  = enc_j(6'h02, 26'h4);
    mem[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    mem[7]  = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
    mem[8]  = enc_j(6'h03, 26'hC);
    mem[12] = enc_i(6'h2B, 5'd0, 5'd31, 16'h0108);
    mem[13] = enc_i(6'h23, 5'd0, 5'd5, 16'h0108);
    mem[14] = enc_i(6'h08, 5'd5, 5'd5, 16'd1);
    mem[15] = enc_i(6'h2B, 5'd0, 5'd5, 16'h010C);
    mem[16] = enc_i(6'h08, 5'd0, 5'd6, 16'h0050);
    mem[17] = enc_r(5'd6, 5'd0, 5'd0, 5'd0, 6'h08);
    mem[20] = enc_i(6'h23, 5'd0, 5'd7, 16'h0006);
    mem[66] = SENT;
    mem[67] = SENT;
    exp_log = '{32'h00, 32'h04, 32'h10, 32'h1C, 32'h20, 32'h30, 32'h108, 32'h34,
                32'h108, 32'h38, 32'h3C, 32'h10C, 32'h40, 32'h44, 32'h50};
    exp_rc  = '{4, 7, 10, 13, 16, 20, 25, 29, 33, 37, 40};
    wait_n = 0;
    do_reset();
    run_until_halt("p3_halt", 200);
    chk("p3_log_size", req_log.size(), 15);
    for (int i = 0; i < 15; i++)
      chk($sformatf("p3_req%0d", i), (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF, exp_log[i]);
    for (int i = 0; i < 11; i++)
      chk($sformatf("p3_ret%0d", i), (i < ret_cyc.size()) ? ret_cyc[i] : -1, exp_rc[i]);
    chk("p3_r31",    mem[66], 32'h24);
    chk("p3_lw_add", mem[67], 32'h25);
    chk("p3_fault",  {29'd0, fault_o}, 32'd2);
    chk("p3_pc",     pc_out_o, 32'h54);
    idle_after_halt("p3_idle");

    // Table-driven single-instruction vectors
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      clear_mem();
      mem[0] = enc_i(6'h0F, 5'd0, 5'd1, v.a[31:16]);
      mem[1] = enc_i(6'h0D, 5'd1, 5'd1, v.a[15:0]);
      mem[2] = enc_i(6'h0F, 5'd0, 5'd2, v.b[31:16]);
      mem[3] = enc_i(6'h0D, 5'd2, 5'd2, v.b[15:0]);
      mem[4] = v.instr;
      mem[5] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0100);
      mem[64] = SENT;
      wait_n = 0;
      do_reset();
      run_until_halt({v.name, "_halt"}, 200);
      chk({v.name, "_result"},  mem[64], v.exp_mem);
      chk({v.name, "_fault"},   {29'd0, fault_o}, {29'd0, v.exp_fault});
      chk({v.name, "_retires"}, retires, v.exp_ret);
      if (v.exp_fault == 3'd4) chk({v.name, "_rd_kept"}, dut.rf_q[3], 32'd0);
    end

    // Memory never ready: timeout after 4 stall cycles
    clear_mem();
    wait_n = 1000;
    do_reset();
    run_until_halt("tmo_halt", 50);
    chk("tmo_stalls", stall_cyc, 4);
    chk("tmo_fault",  {29'd0, fault_o}, 32'd3);
    chk("tmo_req",    {31'd0, bus.req}, 32'd0);
    chk("tmo_nolog",  req_log.size(), 0);

    // Reset in the middle of a stalled fetch
    clear_mem();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0100);
    mem[64] = SENT;
    wait_n = 0;
    do_reset();
    n = 0;
    while (retires < 1 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("mid_first_retire", retires, 1);
    wait_n = 1000;
    repeat (2) @(negedge clk);
    chk("mid_stalled", {31'd0, bus.req & ~bus.ready}, 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("mid_req_drop", {31'd0, bus.req}, 32'd0);
    chk("mid_pc_reset", pc_out_o, 32'd0);
    chk("mid_no_store", mem[64], SENT);
    wait_n = 0;
    do_reset();
    run_until_halt("mid_halt", 100);
    chk("mid_refetch", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'd0);
    chk("mid_result",  mem[64], 32'd7);
    chk("mid_retires", retires, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_processor.md
# multicycle_processor

- Parametrised multi-cycle successor to the single-cycle MIPS-subset processor.
- Executes the same instruction subset over a shared-ALU datapath driven by a state machine, using one unified instruction/data memory port with a ready handshake. Memory wait states are therefore tolerated.
- Adds fault detection, a halt state and a retire strobe.
- Sits at the top of the CPU hierarchy. Memory and testbench attach to the mem_* port.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 255, maximum stall cycles per memory request before a timeout fault; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write (sw), 0 = read.
- mem_addr  output  32  byte address, word-aligned.
- mem_wdata  output  32  store data.
- mem_rdata  input  32  load/fetch data, valid when mem_ready=1.
- mem_ready  input  1  request accepted/completed this cycle.
- retire  output  1  one-cycle pulse when an instruction completes.
- pc_out  output  32  current PC register.
- halted  output  1  core stopped in HALT.
- fault  output  3  halt cause: 0 none, 1 illegal opcode/funct, 2 misaligned address, 3 memory timeout, 4 arithmetic overflow.

## Operation
Supported instructions:
- R-type (op 000000): add, sub, and, or, slt, sll, srl, jr (funct 100000, 100010, 100100, 100101, 101010, 000000, 000010, 001000).
- I-type: addi 001000, slti 001010, andi 001100, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101.
- J-type: j 000010, jal 000011.

Datapath rules:
- andi and ori zero-extend the immediate; all other I-type instructions sign-extend.
- Branch target is PC+4+(sext(imm)<<2).
- Jump target is {PC+4[31:28], imm26, 2'b00}.
- jal writes PC+4 to r31.
- r0 reads as 0; writes to r0 are discarded.
- The register file clears to 0 on reset.

States:
- FETCH: drive mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: IR<=mem_rdata, PC<=PC+4, go to DECODE. If PC[1:0]!=0, go to HALT with fault 2 and issue no request.
- DECODE: latch A=rs and B=rt; compute the branch target; go to EXEC. An unknown opcode or funct goes to HALT with fault 1.
- EXEC:
  - ALU ops go to WB.
  - lw/sw compute A+sext(imm). A misaligned address goes to HALT with fault 2; otherwise go to MEM.
  - beq/bne: if taken, PC<=target; retire; go to FETCH.
  - j, jal and jr: update the PC (jal also writes r31); retire; go to FETCH.
- MEM: mem_req=1, mem_we=1 for sw with mem_wdata=B.
  - lw: on ready, MDR<=mem_rdata, go to WB.
  - sw: on ready, retire and go to FETCH.
- WB: write rd (R-type) or rt (I-type/lw); retire; go to FETCH.
- HALT: mem_req=0 and halted=1. Terminal until reset.

## Timing
Reset:
- Asynchronous entry: state=FETCH, PC=RESET_PC, IR=0, fault=0, halted=0, retire=0, pc_out=RESET_PC.
- mem_req is forced to 0 while reset is asserted. The first fetch request appears in the first cycle after deassertion.
- Reset mid-request abandons the transaction immediately; no register writes occur.

Memory handshake:
- mem_addr, mem_we and mem_wdata are held stable while mem_req=1 until a cycle with mem_ready=1.
- mem_ready in the same cycle as mem_req gives a zero-wait access.
- mem_ready while mem_req=0 is ignored.

Cycle counts with zero-wait memory:
- branch/jump/jr: 3 cycles
- ALU ops and sw: 4 cycles
- lw: 5 cycles
- Each wait cycle adds 1.

Other rules:
- retire is asserted in the final cycle of each instruction and never in HALT.
- Timeout: a counter resets at each new request. The fault fires when the count reaches MEM_TIMEOUT cycles with mem_ready low. mem_req drops in the next cycle.
- Arithmetic is modulo 2^32.
- slt/slti compare signed.
- sll/srl use shamt inst[10:6].

## Configuration
- MULTICYCLE_OVF_TRAP_EN defined: signed overflow on add, sub or addi suppresses the writeback and enters HALT with fault 4; retire is not pulsed.
- Undefined: overflow wraps silently and the result is written back. fault value 4 is never produced.

## Test plan
- Reset with zero-wait memory; program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 -> r3=2, three retire pulses, 12 cycles total.
- sw r3,8(r0) then lw r4,8(r0) with mem_ready delayed 2 cycles each -> memory[8]=2, r4=2, address and data held stable during waits.
- beq r1,r1,+2 at PC 0x10 -> next fetch address 0x1C; bne not taken -> 0x14. jal at 0x20 -> r31=0x24.
- Illegal opcode 6'b111111 -> halted=1, fault=1, mem_req=0 thereafter. lw with address 0x6 -> fault=2 and no MEM request issued.
- mem_ready held low with MEM_TIMEOUT=4 -> fault=3 after 4 stall cycles. Reset asserted mid-wait -> mem_req=0 immediately, next fetch at RESET_PC.
- With MULTICYCLE_OVF_TRAP_EN defined, add 0x7FFFFFFF+1 -> fault=4 and destination register unchanged; without the macro -> result 0x80000000.
